pixel_avg_pool: RTL and testbench
=================================

// Module: pixel_avg_pool
// PURPOSE
//  Upstream feeder of the feedforward FSM: consumes a 28x28 8-bit grayscale frame streamed in raster order,
//  2x2 average-pools it to 14x14 and presents the 196 results as the flattened averaged_pixels vector.
//  Pulses done when a complete frame has been pooled, which the controller uses as its start.
// PARAMETERS
//  IMG_DIM  28  input frame side in pixels; must be even
//  WIDTH    8   pixel bit width (input and output)
//  OUT_DIM  IMG_DIM/2 (localparam) output side; OUT_DIM*OUT_DIM = 196 outputs
// PORTS
//  clk              in   1                      clock
//  reset            in   1                      synchronous, active-high
//  start            in   1                      begin accepting a new frame (honoured in IDLE only)
//  pix_valid        in   1                      pix_data valid this cycle
//  pix_data         in   WIDTH                  input pixel, raster order (row-major, row 0 first)
//  pix_ready        out  1                      block accepts a pixel this cycle
//  averaged_pixels  out  OUT_DIM*OUT_DIM*WIDTH  pooled frame; output k=r*OUT_DIM+c at [k*WIDTH +: WIDTH]
//  busy             out  1                      frame in progress
//  done             out  1                      one-cycle pulse: averaged_pixels holds a complete new frame
// BEHAVIOUR
//  - Reset: state IDLE, row/col counters 0, line buffer 0, averaged_pixels all 0, pix_ready=0, busy=0, done=0.
//  - FSM: IDLE --start--> ACCUM --last pixel accepted--> DONE --> IDLE (unconditional, 1 cycle).
//  - start outside IDLE is ignored; start in IDLE clears row/col and enters ACCUM next cycle.
//  - pix_ready=1 and busy=1 exactly in ACCUM; beat accepted when pix_valid && pix_ready. Gaps allowed.
//  - col counts 0..IMG_DIM-1, wraps to 0 and increments row; row counts 0..IMG_DIM-1.
//  - Line buffer: OUT_DIM partial sums, WIDTH+2 bits each, indexed col>>1.
//    even row, even col: lb[col>>1] <= pix;  even row, odd col: lb[col>>1] <= lb + pix;
//    odd row, even col:  lb[col>>1] <= lb + pix;
//    odd row, odd col:   sum = lb + pix (WIDTH+2 bits, max 4*(2^WIDTH-1), no overflow);
//                        averaged_pixels[((row>>1)*OUT_DIM + (col>>1))*WIDTH +: WIDTH] <= avg(sum).
//  - Last pixel = (row,col) = (IMG_DIM-1, IMG_DIM-1); its output write and ACCUM->DONE happen on the same edge;
//    done=1 in the following cycle (latency 1 cycle from last accepted beat to done).
//  - averaged_pixels changes only on odd-row/odd-col writes; otherwise holds (previous frame persists until overwritten).
//  - Reset mid-frame: immediate return to reset values; no done for the aborted frame.
//  - done is a registered state decode; no combinational path from pix_valid to done or pix_ready.
// CONFIGURATION
//  AVG_ROUND_EN defined:   avg(sum) = (sum + 2) >> 2, round half up; max result 2^WIDTH-1, no saturation needed.
//  AVG_ROUND_EN undefined: avg(sum) = sum >> 2, truncation (default build).
// STRUCTURE
//  - Shared package (nn_pkg): IMG_DIM, OUT_DIM, WIDTH/pixel width, AVG_NR = OUT_DIM*OUT_DIM,
//    FSM state encoding for this block.
//  - One sub-module: pool_line_buffer (OUT_DIM x (WIDTH+2) partial-sum array, write-with-add port);
//    FSM, counters and output register stay in pixel_avg_pool.
// TESTING
//  1. Frame all 8'hFF, pix_valid held high -> 784 beats accepted back-to-back, all 196 outputs 8'hFF, done 1 cycle after beat 784.
//  2. Each 2x2 block = {1,2,3,4} -> every output 8'd2 without AVG_ROUND_EN, 8'd3 with it.
//  3. Pixel value = row (0..27) -> output (r,c) = 2r (vals 2r,2r,2r+1,2r+1: sum 8r+2 -> 2r trunc, 2r+1 round); checks packing order.
//  4. pix_valid random 50% duty -> results identical to test 3; done exactly once; pix_ready low in IDLE/DONE.
//  5. reset asserted after 300 beats, then full new frame -> no done for aborted frame, outputs zero until overwritten, new frame correct.
//  6. start pulsed at beat 100 and during DONE -> ignored; frame completes normally, single done pulse.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the pixel pre-processing front end of the feedforward network:
// frame geometry, pixel width and the state encoding of the average-pool block.
package nn_pkg;

    localparam int IMG_DIM = 28;                // input frame side in pixels (even)
    localparam int OUT_DIM = IMG_DIM / 2;       // pooled frame side
    localparam int WIDTH   = 8;                 // pixel width, input and output
    localparam int AVG_NR  = OUT_DIM * OUT_DIM; // number of pooled outputs

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// Partial-sum line buffer for 2x2 average pooling: one WIDTH+2 bit accumulator per
// output column. Each write either loads the incoming pixel (start of a new 2x2 block)
// or adds it to the stored partial sum. The read port presents stored sum + pixel.
module pool_line_buffer #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int SUM_W = WIDTH + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             load,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] pix,
    output logic [SUM_W-1:0] sum
);

    logic [SUM_W-1:0] lb [DEPTH];

    // Two extra bits hold the sum of four pixels without overflow.
    assign sum = lb[idx] + SUM_W'(pix);

    // Accumulator update: load starts a block, otherwise accumulate.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this small array is cleared on reset so an aborted frame leaves no stale sums; larger RAM-style memories normally skip reset.
            for (int i = 0; i < DEPTH; i++) begin
                lb[i] <= '0;
            end
        end else if (wr_en) begin
            lb[idx] <= load ? SUM_W'(pix) : sum;
        end
    end

endmodule

// File: rtl/pixel_avg_pool.sv
// Streams a 28x28 grayscale frame in raster order, 2x2 average-pools it into a 14x14
// flattened output vector and pulses done once the whole frame has been pooled.
// Build option: define AVG_ROUND_EN for round-half-up averaging; otherwise the
// average truncates.
module pixel_avg_pool
    import nn_pkg::*;
#(
    parameter int IMG_DIM = nn_pkg::IMG_DIM,
    parameter int WIDTH   = nn_pkg::WIDTH
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         pix_valid,
    input  logic [WIDTH-1:0]                             pix_data,
    output logic                                         pix_ready,
    output logic [(IMG_DIM/2)*(IMG_DIM/2)*WIDTH-1:0]     averaged_pixels,
    output logic                                         busy,
    output logic                                         done
);

    localparam int OUT_DIM = IMG_DIM / 2;
    localparam int OUT_NR  = OUT_DIM * OUT_DIM;
    localparam int CNT_W   = $clog2(IMG_DIM);
    localparam int HALF_W  = CNT_W - 1;
    localparam int K_W     = $clog2(OUT_NR);
    localparam int SUM_W   = WIDTH + 2;

    pool_state_t      state;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             lb_load;
    logic [SUM_W-1:0] lb_sum;
    logic [SUM_W-1:0] avg_wide;
    logic [WIDTH-1:0] avg;
    logic [K_W-1:0]   out_idx;

    // Outputs are decodes of the state register, so no input reaches them combinationally.
    assign pix_ready = (state == ST_ACCUM);
    assign busy      = (state == ST_ACCUM);
    assign done      = (state == ST_DONE);

    assign accept   = pix_valid && (state == ST_ACCUM);
    assign last_col = (col == CNT_W'(IMG_DIM - 1));
    assign last_row = (row == CNT_W'(IMG_DIM - 1));

    // The top-left pixel of each 2x2 block restarts the column's partial sum.
    assign lb_load = ~row[0] & ~col[0];

    // Flattened output slot of the 2x2 block containing the current pixel.
    assign out_idx = K_W'(row[CNT_W-1:1]) * K_W'(OUT_DIM) + K_W'(col[CNT_W-1:1]);

    pool_line_buffer #(
        .DEPTH (OUT_DIM),
        .WIDTH (WIDTH),
        .IDX_W (HALF_W),
        .SUM_W (SUM_W)
    ) u_line_buffer (
        .clk   (clk),
        .reset (reset),
        .wr_en (accept),
        .load  (lb_load),
        .idx   (col[CNT_W-1:1]),
        .pix   (pix_data),
        .sum   (lb_sum)
    );

    // Divide the four-pixel sum by four; rounding adds half an LSB before the shift.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        avg_wide = lb_sum;
`ifdef AVG_ROUND_EN
        avg_wide = lb_sum + SUM_W'(2);
`endif
        avg = avg_wide[SUM_W-1:2];
    end

    // Frame FSM with raster row/column counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row   <= '0;
                        col   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            row <= last_row ? '0 : row + CNT_W'(1);
                            if (last_row) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            col <= col + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: written only by the bottom-right pixel of each 2x2 block.
    always_ff @(posedge clk) begin
        if (reset) begin
            averaged_pixels <= '0;
        end else if (accept && row[0] && col[0]) begin
            averaged_pixels[int'(out_idx)*WIDTH +: WIDTH] <= avg;
        end
    end

endmodule

// File: tb/tb_pixel_avg_pool.sv
// Self-checking bench for pixel_avg_pool: table of frame patterns plus hand-written
// reset/abort sequences, all checked against a 2x2 average model over the full frame.
module tb_pixel_avg_pool;

    localparam int IMG  = 28;
    localparam int OD   = IMG / 2;
    localparam int W    = 8;
    localparam int NPIX = IMG * IMG;
    localparam int NOUT = OD * OD;
`ifdef AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              pix_valid;
    logic [W-1:0]      pix_data;
    logic              pix_ready;
    logic [NOUT*W-1:0] averaged_pixels;
    logic              busy;
    logic              done;

    pixel_avg_pool #(.IMG_DIM(IMG), .WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .averaged_pixels (averaged_pixels),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int frame_pix [NPIX];
    int exp_out   [NOUT];

    typedef struct {
        string name;
        int    pattern;    // 0 all 0xFF, 1 blocks {1,2,3,4}, 2 value=row, 3 random
        int    duty;       // pix_valid duty in percent
        bit    start_mid;  // pulse start mid-frame and during DONE
        int    exp_const;  // >=0 every output equals it, -2 output(r,c)=row formula, -1 model only
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint actual, input longint expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int get_out(input int k);
        return int'(averaged_pixels[k*W +: W]);
    endfunction

    task automatic fill_frame(input int pattern);
        for (int r = 0; r < IMG; r++) begin
            for (int c = 0; c < IMG; c++) begin
                case (pattern)
                    0:       frame_pix[r*IMG+c] = 255;
                    1:       frame_pix[r*IMG+c] = 1 + (r % 2) * 2 + (c % 2);
                    2:       frame_pix[r*IMG+c] = r;
                    default: frame_pix[r*IMG+c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    // Reference: average of each 2x2 block computed directly from the stored frame.
    task automatic build_model();
        for (int r = 0; r < OD; r++) begin
            for (int c = 0; c < OD; c++) begin
                int s;
                s = frame_pix[(2*r)*IMG + 2*c]   + frame_pix[(2*r)*IMG + 2*c+1]
                  + frame_pix[(2*r+1)*IMG + 2*c] + frame_pix[(2*r+1)*IMG + 2*c+1];
                exp_out[r*OD+c] = ROUND ? (s + 2) / 4 : s / 4;
            end
        end
    endtask

    function automatic int model_errors();
        int n = 0;
        for (int k = 0; k < NOUT; k++) if (get_out(k) != exp_out[k]) n++;
        return n;
    endfunction

    // Streams beats [first, last) of frame_pix; first==0 pulses start beforehand and
    // last==NPIX checks the done pulse and return to IDLE.
    task automatic stream(input string tag, input int duty, input int first, input int last,
                          input bit start_mid);
        int idx;
        int cycles;
        int bad_ready;
        int bad_done;
        bit v;
        if (first == 0) begin
            check({tag, "_ready_idle"}, pix_ready, 0);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_busy_after_start"}, busy, 1);
        end
        idx = first; cycles = 0; bad_ready = 0; bad_done = 0;
        while (idx < last && cycles < 8000) begin
            v = (duty >= 100) || (int'($urandom_range(99)) < duty);
            pix_valid = v;
            pix_data  = W'(frame_pix[idx]);
            start     = start_mid && (idx == 100);
            if (pix_ready !== 1'b1) bad_ready++;
            if (done !== 1'b0) bad_done++;
            @(posedge clk); #1;
            if (v) idx++;
            cycles++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        check({tag, "_beats_accepted"}, idx, last);
        check({tag, "_ready_low_cycles"}, bad_ready, 0);
        check({tag, "_early_done_cycles"}, bad_done, 0);
        if (duty >= 100) check({tag, "_back_to_back_cycles"}, cycles, last - first);
        if (last == NPIX) begin
            check({tag, "_done_pulse"}, done, 1);
            check({tag, "_ready_in_done"}, pix_ready, 0);
            check({tag, "_busy_in_done"}, busy, 0);
            start = start_mid;
            @(posedge clk); #1;
            start = 1'b0;
            check({tag, "_done_single"}, done, 0);
            check({tag, "_idle_after_done"}, busy, 0);
            @(posedge clk); #1;
            check({tag, "_stays_idle"}, busy, 0);
        end
    endtask

    initial begin
        int nerr;
        int quiet_bad;

        vecs[0] = '{"all_ff",            0, 100, 1'b0, 255};
        vecs[1] = '{"blocks_1234",       1, 100, 1'b0, ROUND ? 3 : 2};
        vecs[2] = '{"row_ramp",          2, 100, 1'b0, -2};
        vecs[3] = '{"row_ramp_gaps",     2, 50,  1'b0, -2};
        vecs[4] = '{"random_full",       3, 100, 1'b0, -1};
        vecs[5] = '{"random_gaps_start", 3, 50,  1'b1, -1};

        reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_outputs_zero", averaged_pixels == '0, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", pix_ready, 0);
        check("reset_done", done, 0);
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        check("idle_ignores_valid", busy, 0);

        for (int i = 0; i < 6; i++) begin
            fill_frame(vecs[i].pattern);
            build_model();
            stream(vecs[i].name, vecs[i].duty, 0, NPIX, vecs[i].start_mid);
            check({vecs[i].name, "_model_errors"}, model_errors(), 0);
            if (vecs[i].exp_const >= 0) begin
                nerr = 0;
                for (int k = 0; k < NOUT; k++) if (get_out(k) != vecs[i].exp_const) nerr++;
                check({vecs[i].name, "_const_errors"}, nerr, 0);
            end else if (vecs[i].exp_const == -2) begin
                nerr = 0;
                for (int k = 0; k < NOUT; k++)
                    if (get_out(k) != (ROUND ? 2*(k/OD) + 1 : 2*(k/OD))) nerr++;
                check({vecs[i].name, "_row_formula_errors"}, nerr, 0);
                check({vecs[i].name, "_out_195"}, get_out(NOUT-1), ROUND ? 27 : 26);
            end
        end

        // Previous frame persists while idle.
        repeat (4) @(posedge clk);
        #1 check("hold_while_idle_errors", model_errors(), 0);

        // Abort a frame with reset after 300 beats.
        fill_frame(3);
        stream("abort", 100, 0, 300, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_outputs_zero", averaged_pixels == '0, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", pix_ready, 0);
        quiet_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (done !== 1'b0) quiet_bad++;
            @(posedge clk); #1;
        end
        check("abort_no_done", quiet_bad, 0);

        // Fresh frame after the abort: rows 0..1 written, the rest still zero.
        fill_frame(2);
        build_model();
        stream("post_abort_a", 100, 0, 2*IMG, 1'b0);
        nerr = 0;
        for (int k = 0; k < OD; k++) if (get_out(k) != exp_out[k]) nerr++;
        check("post_abort_first_row_errors", nerr, 0);
        nerr = 0;
        for (int k = OD; k < NOUT; k++) if (get_out(k) != 0) nerr++;
        check("post_abort_unwritten_nonzero", nerr, 0);
        stream("post_abort_b", 50, 2*IMG, NPIX, 1'b0);
        check("post_abort_model_errors", model_errors(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
